// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
// Holds the FSM state enum, grant/counter widths and data default.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   localparam int GRANT_W    = 3;
   localparam int CNT_W      = 4;
   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO handshake bundle for fifo_wr_arbiter.
// slave: arbiter side; master: producers plus FIFO full source.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_full;
   logic                      fifo_write;
   logic [DATA_W-1:0]         fifo_data;

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_write, fifo_data
   );

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_write, fifo_data
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit from ptr up.
// Ports: req (per-producer), ptr (start index) -> idx, any.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GRANT_W-1:0] ptr,
   output logic [GRANT_W-1:0] idx,
   output logic               any
);

   localparam int SLOTS = 1 << GRANT_W;

   logic [SLOTS-1:0]   req_w;
   logic [GRANT_W-1:0] cand;

   assign req_w = SLOTS'(req);
   assign any   = |req;

   // Walk farthest-first so the nearest hit to ptr wins last.
   always_comb begin
      idx  = '0;
      cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = GRANT_W'((int'(ptr) + k) % NUM_REQ);
         if (req_w[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among producers.
// Ports: clk, rst, bus (slave handshake), busy, grant_id, beat_cnt.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_wr_arbiter_if.slave    bus,
   output logic                busy,
   output logic [GRANT_W-1:0]  grant_id,
   output logic [CNT_W-1:0]    beat_cnt
);

   localparam int SLOTS = 1 << GRANT_W;
   localparam logic [CNT_W-1:0]   LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [GRANT_W-1:0] TOP  = GRANT_W'(NUM_REQ - 1);

   state_t             state;
   logic [GRANT_W-1:0] owner;
   logic [GRANT_W-1:0] rr_ptr;
   logic [GRANT_W-1:0] nxt_ptr;
   logic [GRANT_W-1:0] pick_idx;
   logic               pick_any;
   logic               open;
   logic               own_vld;
   logic               xfer;
   logic [SLOTS-1:0]   vld_w;
   logic [DATA_W-1:0]  dat_w [SLOTS];

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Pad to a power-of-two table so owner indexes it directly.
   assign vld_w = SLOTS'(bus.req_valid);

   for (genvar g = 0; g < SLOTS; g++) begin : g_dat
      if (g < NUM_REQ) begin : g_on
         assign dat_w[g] = bus.req_data[g*DATA_W +: DATA_W];
      end else begin : g_off
         assign dat_w[g] = '0;
      end
   end

   // Nothing moves in a reset cycle, even mid-burst.
   assign open    = (state == BUSY) & ~bus.fifo_full & ~rst;
   assign own_vld = vld_w[owner];
   assign xfer    = open & own_vld;
   assign nxt_ptr = (owner == TOP) ? '0 : owner + GRANT_W'(1);

   assign bus.req_ready  = open ? NUM_REQ'(SLOTS'(1) << owner) : '0;
   assign bus.fifo_write = xfer;
   assign bus.fifo_data  = xfer ? dat_w[owner] : '0;
   assign grant_id       = owner;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  state    <= BUSY;
                  busy     <= 1'b1;
                  owner    <= pick_idx;
                  beat_cnt <= '0;
               end
            end
            BUSY: begin
               // Release on a dropped valid or the final burst beat.
               if (!own_vld || (xfer && beat_cnt == LAST)) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  beat_cnt <= '0;
                  rr_ptr   <= nxt_ptr;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Includes a small FIFO model for the fill/readback scenario.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [2:0] grant_id;
   logic [3:0] beat_cnt;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ   (N),
      .DATA_W    (W),
      .MAX_BURST (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .grant_id (grant_id),
      .beat_cnt (beat_cnt)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   int         sent [N];
   int         tot  [N];
   logic [7:0] base [N];
   bit         inc;

   logic full_drv;
   bit   use_model;
   bit   pop_en;
   int   mcnt = 0;

   logic [7:0] mq[$];
   logic [7:0] wlog[$];
   logic [7:0] rdlog[$];

   logic       tr_wr[$];
   logic       tr_busy[$];
   logic [2:0] tr_gid[$];
   logic [3:0] tr_cnt[$];
   logic [N-1:0] tr_rdy[$];

   assign bus.fifo_full = use_model ? (mcnt == 16) : full_drv;

   // 16-entry sync FIFO model plus a log of every write issued.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         rdlog.delete();
      end else begin
         if (pop_en && mq.size() > 0) rdlog.push_back(mq.pop_front());
         if (bus.fifo_write) begin
            mq.push_back(bus.fifo_data);
            wlog.push_back(bus.fifo_data);
         end
      end
      mcnt <= mq.size();
   end

   always @(negedge clk) begin
      if (!rst)
         assert (!(bus.fifo_write && bus.fifo_full)) else begin
            total_cnt++;
            fail_cnt++;
            $error("FAIL overflow: fifo_write=1 while fifo_full=1");
         end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i] = (sent[i] < tot[i]);
         bus.req_data[i*W +: W] = base[i] + (inc ? 8'(sent[i]) : 8'h00);
      end
   endtask

   task automatic cycle();
      logic [N-1:0] xf;
      @(negedge clk);
      tr_wr.push_back(bus.fifo_write);
      tr_busy.push_back(busy);
      tr_gid.push_back(grant_id);
      tr_cnt.push_back(beat_cnt);
      tr_rdy.push_back(bus.req_ready);
      xf = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (xf[i]) sent[i]++;
      drive();
   endtask

   task automatic clear();
      tr_wr.delete();
      tr_busy.delete();
      tr_gid.delete();
      tr_cnt.delete();
      tr_rdy.delete();
      wlog.delete();
      for (int i = 0; i < N; i++) begin
         sent[i] = 0;
         tot[i]  = 0;
         base[i] = 8'h00;
      end
      inc = 1'b1;
   endtask

   task automatic do_reset();
      clear();
      drive();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int n;
      logic [9:0] pat;
      rst       = 1'b1;
      full_drv  = 1'b0;
      use_model = 1'b0;
      pop_en    = 1'b0;
      clear();
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_write", bus.fifo_write, 0);
      chk("rst_data", bus.fifo_data, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_cnt", beat_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single producer, 6 beats: 4-beat burst, arb gap, 2 beats.
      clear();
      tot[2]  = 6;
      base[2] = 8'h10;
      drive();
      repeat (10) cycle();
      chk("single_len", wlog.size(), 6);
      for (int j = 0; j < 6; j++)
         if (j < wlog.size()) chk("single_data", wlog[j], 8'h10 + j);
      for (int k = 0; k < 10; k++) pat[9-k] = tr_wr[k];
      chk("single_wr_pat", pat, 10'b0111101100);
      for (int k = 0; k < 10; k++) pat[9-k] = tr_busy[k];
      chk("single_busy_pat", pat, 10'b0111101110);
      n = 0;
      for (int k = 0; k < 10; k++)
         if (tr_busy[k] && tr_gid[k] == 3'd2) n++;
      chk("single_gid", n, 7);
      chk("single_cnt_last", tr_cnt[4], 3);
      chk("single_cnt_restart", tr_cnt[6], 0);

      // All four producers always valid: rotation 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < N; i++) begin
         tot[i]  = 1000;
         base[i] = 8'hA0 + 8'(i);
      end
      inc = 1'b0;
      drive();
      repeat (25) cycle();
      chk("rot_len", wlog.size(), 20);
      n = 0;
      for (int j = 0; j < wlog.size(); j++)
         if (wlog[j] !== 8'hA0 + 8'((j / 4) % 4)) n++;
      chk("rot_data_mism", n, 0);
      n = 0;
      for (int k = 0; k < 25; k++)
         if (tr_wr[k] !== ((k % 5) != 0)) n++;
      chk("rot_wr_mism", n, 0);
      chk("rot_gid0", tr_gid[1], 0);
      chk("rot_gid1", tr_gid[6], 1);
      chk("rot_gid2", tr_gid[11], 2);
      chk("rot_gid3", tr_gid[16], 3);
      chk("rot_gid4", tr_gid[21], 0);

      // Early release: producer 0 stops after 2 beats, 3 waiting.
      do_reset();
      tot[0]  = 2;
      base[0] = 8'h30;
      tot[3]  = 3;
      base[3] = 8'h60;
      drive();
      repeat (10) cycle();
      chk("early_cnt", tr_cnt[3], 2);
      chk("early_wr", tr_wr[3], 0);
      chk("early_busy", tr_busy[3], 1);
      chk("early_arb", tr_busy[4], 0);
      chk("early_gid", tr_gid[5], 3);
      chk("early_len", wlog.size(), 5);
      if (wlog.size() == 5) begin
         chk("early_d1", wlog[1], 8'h31);
         chk("early_d2", wlog[2], 8'h60);
      end

      // Back-pressure: full for 5 cycles mid-burst of producer 1.
      do_reset();
      tot[1]  = 4;
      base[1] = 8'h50;
      drive();
      repeat (3) cycle();
      full_drv = 1'b1;
      repeat (5) cycle();
      full_drv = 1'b0;
      repeat (3) cycle();
      n = 0;
      for (int k = 3; k < 8; k++)
         if (!tr_wr[k] && tr_rdy[k] == 0 && tr_cnt[k] == 2 &&
             tr_busy[k] && tr_gid[k] == 3'd1) n++;
      chk("bp_stall", n, 5);
      chk("bp_resume_wr", tr_wr[8], 1);
      chk("bp_resume_cnt", tr_cnt[8], 2);
      chk("bp_len", wlog.size(), 4);
      if (wlog.size() == 4) chk("bp_d3", wlog[3], 8'h53);
      chk("bp_release", tr_busy[10], 0);

      // Reset mid-burst; rr_ptr is 2 here, must return to 0.
      clear();
      tot[1]  = 10;
      base[1] = 8'h70;
      drive();
      repeat (4) cycle();
      chk("mid_cnt", tr_cnt[3], 2);
      chk("mid_gid", tr_gid[3], 1);
      rst = 1'b1;
      cycle();
      rst     = 1'b0;
      tot[2]  = 10;
      base[2] = 8'h80;
      drive();
      repeat (3) cycle();
      chk("mid_rst_wr", tr_wr[4], 0);
      chk("mid_rst_rdy", tr_rdy[4], 0);
      chk("mid_after_busy", tr_busy[5], 0);
      chk("mid_after_rdy", tr_rdy[5], 0);
      chk("mid_after_wr", tr_wr[5], 0);
      chk("mid_after_cnt", tr_cnt[5], 0);
      chk("mid_after_gid", tr_gid[5], 0);
      chk("mid_rr_gid", tr_gid[6], 1);
      chk("mid_rr_busy", tr_busy[6], 1);
      chk("mid_len", wlog.size(), 5);
      if (wlog.size() == 5) chk("mid_d3", wlog[3], 8'h73);

      // Fill a 16-entry FIFO with 20 beats, then drain in order.
      use_model = 1'b1;
      do_reset();
      tot[2] = 20;
      drive();
      repeat (30) cycle();
      chk("fill_cnt", mcnt, 16);
      chk("fill_full", bus.fifo_full, 1);
      chk("fill_wr", tr_wr[29], 0);
      chk("fill_busy", tr_busy[29], 1);
      chk("fill_sent", sent[2], 16);
      pop_en = 1'b1;
      repeat (30) cycle();
      pop_en = 1'b0;
      chk("drain_len", rdlog.size(), 20);
      n = 0;
      for (int j = 0; j < rdlog.size(); j++)
         if (rdlog[j] !== 8'(j)) n++;
      chk("drain_order_mism", n, 0);
      chk("drain_sent", sent[2], 20);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
